// File: rtl/ara_exit_monitor.sv
// ara_exit_monitor: decodes the SoC exit word and shows the result on the board.
// While the SoC runs, LED0 is a heartbeat. Once a valid exit word arrives, the
// LEDs show a pass pattern or a blinking failure code.
// Optional feature macro: ARA_EXIT_MON_UART_EN. When it is defined, the result
// is also sent as one ASCII line (8N1) on uart_tx_o. Without it, uart_tx_o is
// held idle.
module ara_exit_monitor #(
  parameter int HeartbeatDiv = 2**24,
  parameter int BlinkDiv     = 2**23,
  parameter int BaudDiv      = 434
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] exit_i,
  output logic [7:0]  leds_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        uart_tx_o,
  output logic        uart_busy_o
);

  localparam int HbW = (HeartbeatDiv > 1) ? $clog2(HeartbeatDiv) : 1;
  localparam int BlW = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;
  localparam logic [HbW-1:0] HbLast = HbW'(HeartbeatDiv - 1);
  localparam logic [BlW-1:0] BlLast = BlW'(BlinkDiv - 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [63:0]     exit_q, exit_d;
  logic [62:0]     code_q, code_d;
  logic [HbW-1:0]  hb_cnt_q, hb_cnt_d;
  logic            hb_q, hb_d;
  logic [BlW-1:0]  bl_cnt_q, bl_cnt_d;
  logic            bl_q, bl_d;
  logic [7:0]      leds_q, leds_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  // Failure display value: the low code byte, or all-ones when the low byte is
  // zero but the code is not (so a failure is never shown as dark LEDs).
  function automatic logic [7:0] fail_show(input logic [62:0] code);
    if (code[7:0] != 8'h00) begin
      return code[7:0];
    end else begin
      return (|code) ? 8'hFF : 8'h00;
    end
  endfunction

  // Next-state logic for the result FSM, heartbeat/blink counters and LEDs.
  always_comb begin
    exit_d   = exit_i;
    state_d  = state_q;
    code_d   = code_q;
    hb_cnt_d = hb_cnt_q;
    hb_d     = hb_q;
    bl_cnt_d = bl_cnt_q;
    bl_d     = bl_q;

    case (state_q)
      RUN: begin
        if (hb_cnt_q == HbLast) begin
          hb_cnt_d = '0;
          hb_d     = ~hb_q;
        end else begin
          hb_cnt_d = hb_cnt_q + 1'b1;
        end
        if (exit_q[0]) begin
          code_d   = exit_q[63:1];
          state_d  = (exit_q[63:1] == 63'd0) ? PASS : FAIL;
          // Result patterns always start in phase 0.
          bl_cnt_d = '0;
          bl_d     = 1'b0;
        end
      end
      default: begin
        if (bl_cnt_q == BlLast) begin
          bl_cnt_d = '0;
          bl_d     = ~bl_q;
        end else begin
          bl_cnt_d = bl_cnt_q + 1'b1;
        end
      end
    endcase

    // Outputs are derived from next-state values so they change on the same
    // edge as the state itself.
    leds_d = 8'h00;
    case (state_d)
      RUN:     leds_d = {7'b0, hb_d};
      PASS:    leds_d = bl_d ? 8'hAA : 8'h55;
      FAIL:    leds_d = bl_d ? 8'h00 : fail_show(code_d);
      default: leds_d = 8'h00;
    endcase
    done_d = (state_d != RUN);
    pass_d = (state_d == PASS);
  end

  // Result FSM, counters and registered LED/status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      exit_q   <= '0;
      code_q   <= '0;
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
      bl_cnt_q <= '0;
      bl_q     <= 1'b0;
      leds_q   <= 8'h00;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      exit_q   <= exit_d;
      code_q   <= code_d;
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
      bl_cnt_q <= bl_cnt_d;
      bl_q     <= bl_d;
      leds_q   <= leds_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign leds_o = leds_q;
  assign done_o = done_q;
  assign pass_o = pass_q;

`ifdef ARA_EXIT_MON_UART_EN

  localparam int BdW = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam logic [BdW-1:0] BaudLast     = BdW'(BaudDiv - 1);
  // The stop bit is split into STOP (BaudDiv-1 cycles) plus one NEXT cycle,
  // so advancing to the next byte costs no extra idle time on the line.
  localparam logic [BdW-1:0] BaudStopLast = BdW'(BaudDiv - 2);

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_NEXT  = 3'd4
  } tx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic            tx_start_q, tx_start_d;
  logic [BdW-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [4:0]      byte_idx_q, byte_idx_d;
  logic            uart_tx_q, uart_tx_d;
  logic            uart_busy_q, uart_busy_d;

  logic            finish_evt;
  logic [63:0]     code_ext;
  logic [7:0]      hex_chars [16];
  logic [3:0]      hex_sel;
  logic [7:0]      cur_byte;
  logic [4:0]      msg_last;

  // The one RUN->PASS/FAIL transition; it happens once per reset.
  assign finish_evt = (state_q == RUN) && exit_q[0];
  assign code_ext   = {1'b0, code_q};
  assign msg_last   = pass_q ? 5'd2 : 5'd18;

  // Uppercase ASCII hex digits of the zero-extended code, MSB nibble first.
  for (genvar gi = 0; gi < 16; gi++) begin : g_hex
    logic [3:0] nib;
    assign nib = code_ext[63-4*gi -: 4];
    assign hex_chars[gi] = (nib < 4'd10) ? (8'h30 + {4'h0, nib})
                                         : (8'h37 + {4'h0, nib});
  end

  // Message byte selection: "P\r\n" or "F" + 16 hex digits + "\r\n".
  always_comb begin
    hex_sel  = 4'(byte_idx_d - 5'd1);
    cur_byte = 8'h0A;
    if (pass_q) begin
      case (byte_idx_d)
        5'd0:    cur_byte = 8'h50;
        5'd1:    cur_byte = 8'h0D;
        default: cur_byte = 8'h0A;
      endcase
    end else begin
      if (byte_idx_d == 5'd0) begin
        cur_byte = 8'h46;
      end else if (byte_idx_d <= 5'd16) begin
        cur_byte = hex_chars[hex_sel];
      end else if (byte_idx_d == 5'd17) begin
        cur_byte = 8'h0D;
      end else begin
        cur_byte = 8'h0A;
      end
    end
  end

  // TX FSM next state: 8N1 framing, back-to-back bytes.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_start_d = tx_start_q | finish_evt;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;

    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start_q) begin
          tx_state_d = TX_START;
          tx_start_d = 1'b0;
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          byte_idx_d = 5'd0;
        end
      end
      TX_START: begin
        if (baud_cnt_q == BaudLast) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          tx_state_d = TX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_cnt_q == BaudLast) begin
          baud_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_state_d = TX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_cnt_q == BaudStopLast) begin
          baud_cnt_d = '0;
          tx_state_d = TX_NEXT;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      TX_NEXT: begin
        if (byte_idx_q == msg_last) begin
          tx_state_d = TX_IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 5'd1;
          tx_state_d = TX_START;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Line level and busy flag follow the next TX state so both are registered.
  always_comb begin
    uart_tx_d = 1'b1;
    case (tx_state_d)
      TX_START: uart_tx_d = 1'b0;
      TX_DATA:  uart_tx_d = cur_byte[bit_idx_d];
      default:  uart_tx_d = 1'b1;
    endcase
    uart_busy_d = (tx_state_d != TX_IDLE);
  end

  // TX state register; reset aborts any frame in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state_q  <= TX_IDLE;
      tx_start_q  <= 1'b0;
      baud_cnt_q  <= '0;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= 5'd0;
      uart_tx_q   <= 1'b1;
      uart_busy_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_start_q  <= tx_start_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      uart_tx_q   <= uart_tx_d;
      uart_busy_q <= uart_busy_d;
    end
  end

  assign uart_tx_o   = uart_tx_q;
  assign uart_busy_o = uart_busy_q;

`else

  assign uart_tx_o   = 1'b1;
  assign uart_busy_o = 1'b0;

`endif

endmodule

// File: tb/tb_ara_exit_monitor.sv
// Testbench for ara_exit_monitor. Stimulus queues expected LED/status samples
// and expected UART frames; independent monitor and receiver processes check
// them as the DUT produces them.
`timescale 1ns/1ps
module tb_ara_exit_monitor;

  localparam int HB = 4;
  localparam int BL = 8;
  localparam int BD = 4;
`ifdef ARA_EXIT_MON_UART_EN
  localparam bit UART_EN = 1'b1;
`else
  localparam bit UART_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [63:0] exit_i = '0;
  logic [7:0]  leds_o;
  logic        done_o;
  logic        pass_o;
  logic        uart_tx_o;
  logic        uart_busy_o;

  ara_exit_monitor #(
    .HeartbeatDiv(HB),
    .BlinkDiv    (BL),
    .BaudDiv     (BD)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .exit_i     (exit_i),
    .leds_o     (leds_o),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .uart_tx_o  (uart_tx_o),
    .uart_busy_o(uart_busy_o)
  );

  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] leds;
    logic       done;
    logic       pass;
    logic       use_uart;
    logic       tx;
    logic       busy;
    string      name;
  } exp_t;

  typedef struct {
    int         start;
    logic [7:0] data;
  } frame_t;

  exp_t   exp_q[$];
  frame_t frm_q[$];
  int     n_checks = 0;
  int     n_pass = 0;
  bit     rx_en = 1'b0;

  function automatic void push(input int c, input logic [7:0] l, input logic d,
                               input logic p, input string nm);
    exp_t e;
    e.cyc = c; e.leds = l; e.done = d; e.pass = p;
    e.use_uart = !UART_EN; e.tx = 1'b1; e.busy = 1'b0; e.name = nm;
    exp_q.push_back(e);
  endfunction

  function automatic void push_u(input int c, input logic [7:0] l, input logic d,
                                 input logic p, input logic t, input logic b,
                                 input string nm);
    exp_t e;
    e.cyc = c; e.leds = l; e.done = d; e.pass = p;
    e.use_uart = 1'b1; e.tx = t; e.busy = b; e.name = nm;
    exp_q.push_back(e);
  endfunction

  function automatic void push_frame(input int s, input logic [7:0] b);
    frame_t f;
    f.start = s; f.data = b;
    frm_q.push_back(f);
  endfunction

  task automatic go_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int r);
    rst_i  = 1'b1;
    exit_i = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    r = cyc;
  endtask

  // Monitor: compare LED/status outputs at the cycles the stimulus asked for.
  exp_t cur;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      cur = exp_q.pop_front();
      n_checks++;
      if (cur.cyc != cyc) begin
        $display("FAIL %s: sample for cycle %0d missed (now %0d)", cur.name, cur.cyc, cyc);
      end else if (leds_o !== cur.leds || done_o !== cur.done || pass_o !== cur.pass ||
                   (cur.use_uart && (uart_tx_o !== cur.tx || uart_busy_o !== cur.busy))) begin
        $display("FAIL %s @%0d: got leds=%h done=%b pass=%b tx=%b busy=%b, want leds=%h done=%b pass=%b tx=%b busy=%b (uart %s)",
                 cur.name, cyc, leds_o, done_o, pass_o, uart_tx_o, uart_busy_o,
                 cur.leds, cur.done, cur.pass, cur.tx, cur.busy, cur.use_uart ? "checked" : "ignored");
      end else begin
        n_pass++;
        $display("ok   %s @%0d leds=%h done=%b pass=%b tx=%b busy=%b",
                 cur.name, cyc, leds_o, done_o, pass_o, uart_tx_o, uart_busy_o);
      end
    end
  end

  // UART receiver: decode each frame at mid-bit and compare with the queue.
  initial begin : rx
    int         s;
    logic [7:0] b;
    logic       stop_bit;
    frame_t     f;
    forever begin
      @(negedge clk);
      if (rx_en && uart_tx_o === 1'b0) begin
        s = cyc;
        repeat (BD + BD / 2) @(negedge clk);
        b[0] = uart_tx_o;
        for (int i = 1; i < 8; i++) begin
          repeat (BD) @(negedge clk);
          b[i] = uart_tx_o;
        end
        repeat (BD) @(negedge clk);
        stop_bit = uart_tx_o;
        n_checks++;
        if (frm_q.size() == 0) begin
          $display("FAIL uart_frame: unexpected frame at %0d data=%h", s, b);
        end else begin
          f = frm_q.pop_front();
          if (b !== f.data || stop_bit !== 1'b1 || s != f.start) begin
            $display("FAIL uart_frame: got data=%h stop=%b start=%0d, want data=%h stop=1 start=%0d",
                     b, stop_bit, s, f.data, f.start);
          end else begin
            n_pass++;
            $display("ok   uart_frame start=%0d data=%h", s, b);
          end
        end
      end
    end
  end

  initial begin : stim
    int    r;
    string m;
    logic  u_busy;
    logic  u_tx_lo;
    u_busy  = UART_EN;
    u_tx_lo = !UART_EN;

    // Heartbeat: LED0 toggles every HB cycles, nothing done.
    do_reset(r);
    for (int j = 0; j <= 20; j++) begin
      push(r + j, (((j / HB) % 2) == 1) ? 8'h01 : 8'h00, 1'b0, 1'b0, "heartbeat");
    end
    go_to(r + 21);

    // Pass: exit word 1, later words ignored.
    do_reset(r);
    exit_i = 64'h1;
    push(r + 1,  8'h00, 1'b0, 1'b0, "pass_latency");
    push(r + 2,  8'h55, 1'b1, 1'b1, "pass_entry");
    push(r + 9,  8'h55, 1'b1, 1'b1, "pass_phase0_end");
    push(r + 10, 8'hAA, 1'b1, 1'b1, "pass_phase1");
    push(r + 17, 8'hAA, 1'b1, 1'b1, "pass_phase1_end");
    push(r + 18, 8'h55, 1'b1, 1'b1, "pass_phase0_again");
    push(r + 25, 8'h55, 1'b1, 1'b1, "pass_ignore_7a");
    push(r + 26, 8'hAA, 1'b1, 1'b1, "pass_ignore_7b");
    push(r + 30, 8'hAA, 1'b1, 1'b1, "pass_ignore_0");
    go_to(r + 12);
    exit_i = 64'h7;
    go_to(r + 27);
    exit_i = 64'h0;
    go_to(r + 31);

    // Fail with code 0x2A.
    do_reset(r);
    exit_i = 64'h55;
    push(r + 1,  8'h00, 1'b0, 1'b0, "fail_latency");
    push(r + 2,  8'h2A, 1'b1, 1'b0, "fail_entry");
    push(r + 9,  8'h2A, 1'b1, 1'b0, "fail_phase0_end");
    push(r + 10, 8'h00, 1'b1, 1'b0, "fail_phase1");
    push(r + 17, 8'h00, 1'b1, 1'b0, "fail_phase1_end");
    push(r + 18, 8'h2A, 1'b1, 1'b0, "fail_phase0_again");
    go_to(r + 19);

    // Fail with code 0x100: low byte zero shows as FF.
    do_reset(r);
    exit_i = 64'h201;
    push(r + 2,  8'hFF, 1'b1, 1'b0, "failhi_entry");
    push(r + 9,  8'hFF, 1'b1, 1'b0, "failhi_phase0_end");
    push(r + 10, 8'h00, 1'b1, 1'b0, "failhi_phase1");
    push(r + 18, 8'hFF, 1'b1, 1'b0, "failhi_phase0_again");
    go_to(r + 19);

    // Even word ignored, then fail, then reset during FAIL.
    do_reset(r);
    exit_i = 64'h54;
    push(r + 2,  8'h00, 1'b0, 1'b0, "even_run_a");
    push(r + 4,  8'h01, 1'b0, 1'b0, "even_run_b");
    push(r + 7,  8'h01, 1'b0, 1'b0, "even_run_c");
    push(r + 8,  8'h00, 1'b0, 1'b0, "even_run_d");
    push(r + 11, 8'h00, 1'b0, 1'b0, "even_then_odd_latency");
    push(r + 12, 8'h2A, 1'b1, 1'b0, "even_then_fail");
    push(r + 14, 8'h2A, 1'b1, 1'b0, "fail_before_reset");
    push(r + 15, 8'h00, 1'b0, 1'b0, "reset_in_fail");
    push(r + 18, 8'h00, 1'b0, 1'b0, "run_resumed_a");
    push(r + 19, 8'h01, 1'b0, 1'b0, "run_resumed_b");
    go_to(r + 10);
    exit_i = 64'h55;
    go_to(r + 14);
    rst_i  = 1'b1;
    exit_i = 64'h0;
    go_to(r + 15);
    rst_i = 1'b0;
    go_to(r + 20);

    // UART result line for code 0x2A: 19 frames of 10*BD cycles.
    do_reset(r);
    rx_en  = 1'b1;
    exit_i = 64'h55;
    if (UART_EN) begin
      m = "F000000000000002A";
      for (int i = 0; i < 17; i++) begin
        push_frame(r + 3 + 40 * i, m[i]);
      end
      push_frame(r + 3 + 40 * 17, 8'h0D);
      push_frame(r + 3 + 40 * 18, 8'h0A);
    end
    push_u(r + 2,   8'h2A, 1'b1, 1'b0, 1'b1,    1'b0,   "uart_before_start");
    push_u(r + 3,   8'h2A, 1'b1, 1'b0, u_tx_lo, u_busy, "uart_start");
    push_u(r + 762, 8'h00, 1'b1, 1'b0, 1'b1,    u_busy, "uart_last_cycle");
    push_u(r + 763, 8'h00, 1'b1, 1'b0, 1'b1,    1'b0,   "uart_done");
    go_to(r + 770);
    rx_en = 1'b0;

    // Reset in the middle of the first frame aborts transmission.
    do_reset(r);
    exit_i = 64'h55;
    push_u(r + 4,  8'h2A, 1'b1, 1'b0, u_tx_lo, u_busy, "uart_midframe");
    push_u(r + 5,  8'h00, 1'b0, 1'b0, 1'b1,    1'b0,   "uart_abort");
    push_u(r + 12, 8'h01, 1'b0, 1'b0, 1'b1,    1'b0,   "uart_stays_idle_a");
    push_u(r + 50, 8'h01, 1'b0, 1'b0, 1'b1,    1'b0,   "uart_stays_idle_b");
    go_to(r + 4);
    rst_i  = 1'b1;
    exit_i = 64'h0;
    go_to(r + 5);
    rst_i = 1'b0;
    go_to(r + 52);

    // Anything still queued was never observed.
    repeat (5) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      n_checks++;
      $display("FAIL %s: sample for cycle %0d never taken", cur.name, cur.cyc);
    end
    while (frm_q.size() > 0) begin
      frame_t f;
      f = frm_q.pop_front();
      n_checks++;
      $display("FAIL uart_frame: expected data=%h at %0d, got no frame", f.data, f.start);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
